// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and the capture FSM state type.
// The HDMI reader and the DPRAM depth are sized from the same constants.
package fb_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FB_WORDS = H_ACTIVE * V_ACTIVE / 4;
  localparam int ADDR_W   = 17;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    ACTIVE    = 2'd2,
    FULL      = 2'd3
  } fb_state_e;

endpackage

// File: rtl/fb_byte_packer.sv
// Packs accepted pixel bytes into 32-bit little-endian words.
// A completed word is presented for exactly one cycle, one cycle after its fourth byte.
module fb_byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q;
  logic [23:0] shift_q;
  logic [31:0] word_q;
  logic        word_valid_q;

  // Lane fill and word hand-off; clear drops any partial word by rewinding the lane.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q       <= 2'd0;
      shift_q      <= 24'd0;
      word_q       <= 32'd0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (clear_i) begin
        lane_q <= 2'd0;
      end else if (valid_i) begin
        lane_q <= lane_q + 2'd1;
        case (lane_q)
          2'd0: shift_q[7:0]   <= byte_i;
          2'd1: shift_q[15:8]  <= byte_i;
          2'd2: shift_q[23:16] <= byte_i;
          default: begin
            word_q       <= {byte_i, shift_q};
            word_valid_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/mipi_fb_writer.sv
// Frame-buffer write side: crops the CSI byte stream to H_ACTIVE x V_ACTIVE,
// packs it into words and drives DPRAM port A so pixel (x,y) lands at byte y*H_ACTIVE+x.
module mipi_fb_writer #(
  parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
  parameter int V_ACTIVE = fb_pkg::V_ACTIVE,
  parameter int ADDR_W   = fb_pkg::ADDR_W
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_data,
  output logic              frame_done,
  output logic [9:0]        line_cnt,
  output logic              err_short
);

  import fb_pkg::*;

  localparam int                XW         = $clog2(H_ACTIVE + 1);
  localparam logic [XW-1:0]     X_END      = XW'(H_ACTIVE);
  localparam logic [XW-1:0]     X_LAST     = XW'(H_ACTIVE - 1);
  localparam logic [9:0]        Y_END      = 10'(V_ACTIVE);
  localparam logic [9:0]        Y_LAST     = 10'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(H_ACTIVE / 4);

  fb_state_e         state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              accept;
  logic              packClear;

  // Next-state logic: frame/line boundaries take priority over pixel bytes in the same cycle.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    base_d    = base_q;
    addr_d    = addr_q;
    err_d     = err_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    packClear = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          x_d       = '0;
          y_d       = '0;
          base_d    = '0;
          packClear = 1'b1;
          state_d   = line_start ? ACTIVE : WAIT_LINE;
        end
      end

      WAIT_LINE, ACTIVE: begin
        if (frame_start) begin
          err_d     = 1'b1;
          x_d       = '0;
          y_d       = '0;
          base_d    = '0;
          packClear = 1'b1;
          state_d   = line_start ? ACTIVE : WAIT_LINE;
        end else if (line_start) begin
          x_d       = '0;
          packClear = 1'b1;
          if (state_q == WAIT_LINE) begin
            state_d = ACTIVE;
          end else begin
            if (x_q != X_END) err_d = 1'b1;
            y_d    = y_q + 10'd1;
            base_d = base_q + LINE_WORDS;
            if (y_q + 10'd1 == Y_END) state_d = FULL;
          end
        end else if (state_q == ACTIVE && pix_valid && x_q != X_END) begin
          accept = 1'b1;
          x_d    = x_q + XW'(1);
          if (x_q[1:0] == 2'b11) addr_d = base_q + ADDR_W'(x_q >> 2);
          if (x_q == X_LAST && y_q == Y_LAST) state_d = FULL;
        end
      end

      FULL: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, position, address and status registers.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  fb_byte_packer uPacker (
    .clk_i        (sys_clk),
    .rst_i        (reset),
    .clear_i      (packClear),
    .valid_i      (accept),
    .byte_i       (pix_data),
    .word_valid_o (ram_we),
    .word_o       (ram_data)
  );

  assign ram_addr   = addr_q;
  assign frame_done = done_q;
  assign line_cnt   = y_q;
  assign err_short  = err_q;

endmodule
